ram_loader: RTL and testbench

//  Upstream write-port owner of the 48 KB system RAM. Clears RAM after reset, writes

---
 rtl/ram_loader_pkg.sv | 10 +
 rtl/ram_loader_rst_stretch.sv | 35 +++
 rtl/ram_loader.sv | 136 +++++++++++++
 tb/tb_ram_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared types and widths for the ram_loader block.
package ram_loader_pkg;

    localparam int IOCTL_AW = 25;
    localparam int RAM_AW   = 16;
    localparam int HOLD_W   = 16;

    typedef enum logic [1:0] {CLEAR, LOAD, HOLD, IDLE} state_t;

endpackage

// File: rtl/ram_loader_rst_stretch.sv
// CPU reset stretcher: holds cpu_reset while the loader is busy and for
// RST_HOLD cycles after busy falls.
module rst_stretch
    import ram_loader_pkg::*;
#(
    parameter int RST_HOLD = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic busy_i,
    output logic cpu_reset_o
);

    logic [HOLD_W-1:0] cnt_q;
    logic              rst_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= HOLD_W'(RST_HOLD);
            rst_q <= 1'b1;
        end else if (busy_i) begin
            cnt_q <= HOLD_W'(RST_HOLD);
            rst_q <= 1'b1;
        end else if (cnt_q > HOLD_W'(1)) begin
            cnt_q <= cnt_q - HOLD_W'(1);
        end else begin
            cnt_q <= '0;
            rst_q <= 1'b0;
        end
    end

    // busy_i is ORed in so reset asserts in the same cycle a download starts
    assign cpu_reset_o = rst_q | busy_i;

endmodule

// File: rtl/ram_loader.sv
// System RAM write-port owner: post-reset clear, ioctl image download, CPU passthrough.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running checksum output.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int          SIZE      = 49152,
    parameter logic [15:0] LOAD_BASE = 16'h4000,
    parameter logic [7:0]  CLEAR_VAL = 8'h00,
    parameter int          RST_HOLD  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic [RAM_AW-1:0]   cpu_addr,
    input  logic [7:0]          cpu_din,
    input  logic                cpu_we,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [7:0]          ram_din,
    output logic                ram_we,
    output logic                cpu_reset,
    output logic                load_busy,
    output logic [IOCTL_AW-1:0] bytes_loaded,
    output logic                overflow
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]          checksum
`endif
);

    localparam logic [IOCTL_AW:0]   SIZE_X   = (IOCTL_AW+1)'(SIZE);
    localparam logic [RAM_AW-1:0]   LAST_CLR = RAM_AW'(SIZE - 1);

    state_t              state_q;
    logic [RAM_AW-1:0]   clr_addr_q;
    logic [RAM_AW-1:0]   wr_addr_q;
    logic [7:0]          wr_din_q;
    logic                wr_we_q;
    logic                own_q;
    logic                ovf_q;
    logic [IOCTL_AW-1:0] bytes_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    logic [IOCTL_AW:0]   load_addr_d;
    logic                take_d;

    // Range check is done one bit wider than ioctl_addr so large offsets cannot wrap into RAM
    assign load_addr_d = {1'b0, ioctl_addr} + {{(IOCTL_AW + 1 - RAM_AW){1'b0}}, LOAD_BASE};
    assign take_d      = ioctl_wr && (load_addr_d < SIZE_X);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            wr_addr_q  <= '0;
            wr_din_q   <= '0;
            wr_we_q    <= 1'b0;
            own_q      <= 1'b1;
            bytes_q    <= '0;
            ovf_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            wr_we_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (take_d) begin
                        wr_addr_q <= LOAD_BASE + ioctl_addr[RAM_AW-1:0];
                        wr_din_q  <= ioctl_dout;
                        wr_we_q   <= 1'b1;
                        bytes_q   <= bytes_q + IOCTL_AW'(1);
`ifdef LOADER_CHECKSUM_EN
                        csum_q    <= csum_q + ioctl_dout;
`endif
                    end else if (ioctl_wr) begin
                        ovf_q <= 1'b1;
                    end
                    // Keep the port one more cycle if the final strobe is still being written
                    if (!ioctl_download) begin
                        state_q <= HOLD;
                        own_q   <= take_d;
                    end
                end
                default: begin
                    if (ioctl_download) begin
                        state_q <= LOAD;
                        own_q   <= 1'b1;
                        bytes_q <= '0;
                        ovf_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end else if (state_q == CLEAR) begin
                        wr_addr_q  <= clr_addr_q;
                        wr_din_q   <= CLEAR_VAL;
                        wr_we_q    <= 1'b1;
                        clr_addr_q <= clr_addr_q + RAM_AW'(1);
                        if (clr_addr_q == LAST_CLR) begin
                            state_q <= HOLD;
                        end
                    end else begin
                        own_q <= 1'b0;
                        if (state_q == HOLD && !cpu_reset) begin
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    rst_stretch #(
        .RST_HOLD (RST_HOLD)
    ) u_rst_stretch (
        .clk         (clk),
        .reset_n     (reset_n),
        .busy_i      (own_q),
        .cpu_reset_o (cpu_reset)
    );

    assign ram_addr     = own_q ? wr_addr_q : cpu_addr;
    assign ram_din      = own_q ? wr_din_q  : cpu_din;
    assign ram_we       = own_q ? wr_we_q   : cpu_we;
    assign load_busy    = own_q;
    assign bytes_loaded = bytes_q;
    assign overflow     = ovf_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum     = csum_q;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: directed sequence with randomized data
// checked against a simple address-map/count model.
module tb_ram_loader;

    localparam int SIZE      = 49152;
    localparam int LOAD_BASE = 'h4000;
    localparam int RST_HOLD  = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        cpu_reset;
    logic        load_busy;
    logic [24:0] bytes_loaded;
    logic        overflow;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    always #5 clk = ~clk;

    ram_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .cpu_addr       (cpu_addr),
        .cpu_din        (cpu_din),
        .cpu_we         (cpu_we),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_we         (ram_we),
        .cpu_reset      (cpu_reset),
        .load_busy      (load_busy),
        .bytes_loaded   (bytes_loaded),
        .overflow       (overflow)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the loader's visible counters
    int exp_bytes = 0;
    int exp_ovf   = 0;
    int exp_sum   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic measure_hold(output int n);
        n = 0;
        while (cpu_reset === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic enter_load();
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b0;
        cpu_we         = 1'b1;
        cpu_addr       = 16'($urandom);
        cpu_din        = 8'($urandom);
        tick();
        exp_bytes = 0;
        exp_ovf   = 0;
        exp_sum   = 0;
        check("entry_we", 32'(ram_we), 32'd0);
        check("entry_busy", 32'(load_busy), 32'd1);
        check("entry_cpurst", 32'(cpu_reset), 32'd1);
        check("entry_bytes", 32'(bytes_loaded), 32'd0);
        check("entry_ovf", 32'(overflow), 32'd0);
    endtask

    task automatic load_cycle(input bit dl, input bit wr, input logic [24:0] a, input logic [7:0] d);
        longint      mapped;
        logic [15:0] ea;
        mapped         = longint'(LOAD_BASE) + longint'(a);
        ea             = mapped[15:0];
        ioctl_download = dl;
        ioctl_wr       = wr;
        ioctl_addr     = a;
        ioctl_dout     = d;
        cpu_we         = 1'b1;
        cpu_addr       = 16'($urandom);
        cpu_din        = 8'($urandom);
        tick();
        ioctl_wr = 1'b0;
        if (wr && mapped < longint'(SIZE)) begin
            exp_bytes++;
            exp_sum = (exp_sum + int'(d)) % 256;
            check("ld_we", 32'(ram_we), 32'd1);
            check("ld_addr", 32'(ram_addr), 32'(ea));
            check("ld_din", 32'(ram_din), 32'(d));
        end else begin
            if (wr) exp_ovf = 1;
            check("ld_nowe", 32'(ram_we), 32'd0);
        end
        if (dl) check("ld_busy", 32'(load_busy), 32'd1);
        check("ld_cpurst", 32'(cpu_reset), 32'd1);
        check("ld_bytes", 32'(bytes_loaded), 32'(exp_bytes));
        check("ld_ovf", 32'(overflow), 32'(exp_ovf));
`ifdef LOADER_CHECKSUM_EN
        check("ld_csum", 32'(checksum), 32'(exp_sum));
`endif
    endtask

    task automatic end_download(input logic [24:0] a, input logic [7:0] d);
        int n;
        load_cycle(1'b0, 1'b1, a, d);
        cpu_we = 1'b0;
        tick();
        check("end_busy", 32'(load_busy), 32'd0);
        check("end_we", 32'(ram_we), 32'd0);
        check("end_cpurst", 32'(cpu_reset), 32'd1);
        measure_hold(n);
        check("end_hold", 32'(n), 32'(RST_HOLD));
    endtask

    initial begin
        int idx;
        int bad;
        int n;
        logic [24:0] ra;

        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        cpu_addr       = 16'h1111;
        cpu_din        = 8'h22;
        cpu_we         = 1'b1;
        repeat (3) tick();
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_cpurst", 32'(cpu_reset), 32'd1);
        check("rst_busy", 32'(load_busy), 32'd1);
        check("rst_bytes", 32'(bytes_loaded), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check("rst_csum", 32'(checksum), 32'd0);
`endif

        // Full clear with random CPU traffic that must be ignored
        reset_n = 1'b1;
        idx = 0;
        bad = 0;
        for (int c = 0; c < SIZE + 8; c++) begin
            cpu_we   = 1'($urandom_range(0, 1));
            cpu_addr = 16'($urandom);
            cpu_din  = 8'($urandom);
            tick();
            if (load_busy !== 1'b1) break;
            if (ram_we === 1'b1) begin
                if (ram_addr !== 16'(idx) || ram_din !== 8'h00) bad++;
                idx++;
            end else begin
                bad++;
            end
        end
        check("clr_pulses", 32'(idx), 32'(SIZE));
        check("clr_bad", 32'(bad), 32'd0);
        check("clr_done", 32'(load_busy), 32'd0);
        check("clr_cpurst_at_fall", 32'(cpu_reset), 32'd1);
        cpu_we = 1'b0;
        measure_hold(n);
        check("clr_hold", 32'(n), 32'(RST_HOLD));

        // IDLE passthrough
        cpu_addr = 16'h1234;
        cpu_din  = 8'h5A;
        cpu_we   = 1'b1;
        #1;
        check("pt_addr", 32'(ram_addr), 32'h1234);
        check("pt_din", 32'(ram_din), 32'h5A);
        check("pt_we", 32'(ram_we), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 16'($urandom);
            cpu_din  = 8'($urandom);
            cpu_we   = 1'($urandom_range(0, 1));
            #1;
            check("ptr_addr", 32'(ram_addr), 32'(cpu_addr));
            check("ptr_din", 32'(ram_din), 32'(cpu_din));
            check("ptr_we", 32'(ram_we), 32'(cpu_we));
        end
        tick();

        // First download: directed bytes, boundaries, then random traffic
        enter_load();
        load_cycle(1'b1, 1'b1, 25'd0, 8'hAA);
        load_cycle(1'b1, 1'b1, 25'd1, 8'hBB);
        load_cycle(1'b1, 1'b1, 25'd2, 8'hCC);
        check("three_bytes", 32'(bytes_loaded), 32'd3);
`ifdef LOADER_CHECKSUM_EN
        check("three_csum", 32'(checksum), 32'h31);
`endif
        load_cycle(1'b1, 1'b1, 25'h0_7FFF, 8'h5C);
        load_cycle(1'b1, 1'b1, 25'h0_8000, 8'h77);
        load_cycle(1'b1, 1'b1, 25'h1_0005, 8'h66);
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) ra = 25'($urandom);
            else ra = 25'($urandom_range(0, 'h7FFF));
            load_cycle(1'b1, 1'($urandom_range(0, 1)), ra, 8'($urandom));
        end
        end_download(25'd5, 8'($urandom));

        // Second download: entry clears counters, then async reset mid-load
        enter_load();
        load_cycle(1'b1, 1'b1, 25'h0_9000, 8'h11);
        load_cycle(1'b1, 1'b1, 25'd3, 8'($urandom));
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        #2;
        check("arst_we", 32'(ram_we), 32'd0);
        check("arst_cpurst", 32'(cpu_reset), 32'd1);
        check("arst_busy", 32'(load_busy), 32'd1);
        check("arst_bytes", 32'(bytes_loaded), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;

        // Partial clear, then a download abandons it at clr_addr 100
        idx = 0;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            cpu_we   = 1'($urandom_range(0, 1));
            cpu_addr = 16'($urandom);
            tick();
            if (ram_we === 1'b1 && ram_addr === 16'(c)) idx++;
            else bad++;
        end
        check("pclr_pulses", 32'(idx), 32'd100);
        check("pclr_last", 32'(ram_addr), 32'd99);
        enter_load();
        load_cycle(1'b1, 1'b0, 25'd0, 8'h00);
        load_cycle(1'b1, 1'b0, 25'd0, 8'h00);
        load_cycle(1'b1, 1'b1, 25'd0, 8'($urandom));
        end_download(25'd1, 8'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
